// File: rtl/p_fetch_stage.sv
// Instruction-fetch stage: PC register, imem address and IF/ID register.
// Idle until the first load_pc, then fetches, stalls and redirects.
module p_fetch_stage #(
    parameter logic [31:0] START_PC = 32'h0040_0020,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (state_q == IDLE) begin
            pc_d    = START_PC;
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            if (load_pc) begin
                state_d = RUN;
            end
        end else if (load_pc) begin
            pc_d    = START_PC;
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (branch_taken) begin
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (jump) begin
            // Region bits come from the jump's own PC+4 held in IF/ID.
            pc_d    = {pc4_q[31:28], jump_index, 2'b00};
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

endmodule

// File: tb/tb_p_fetch_stage.sv
// Directed bench for p_fetch_stage with a small instruction-memory table.
// Expected values are hand-computed constants.
module tb_p_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int total = 0;
    int bad   = 0;

    p_fetch_stage dut (
        .clk(clk),
        .reset(reset),
        .load_pc(load_pc),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_index(jump_index),
        .imem_data(imem_data),
        .imem_addr(imem_addr),
        .pc_out(pc_out),
        .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0040_0020: mem_rd = 32'h1111_0001;
            32'h0040_0024: mem_rd = 32'h2222_0002;
            32'h0040_0028: mem_rd = 32'h3333_0003;
            32'h0040_002C: mem_rd = 32'h0810_0040;
            32'h0040_0100: mem_rd = 32'h5555_0005;
            default:       mem_rd = 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb imem_data = mem_rd(imem_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] p4,
                           input logic v);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".addr"}, imem_addr, pc);
        check({tag, ".instr"}, if_id_instr, ins);
        check({tag, ".pc4"}, if_id_pc4, p4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    initial begin
        reset = 1'b0;
        load_pc = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        jump = 1'b0;
        jump_index = 26'd0;

        step();
        chk_all("rst0", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        step();
        chk_all("rst1", 32'h0040_0020, 32'd0, 32'd0, 1'b0);

        reset = 1'b1;
        step();
        chk_all("idle0", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0040_0500;
        jump = 1'b1;
        step();
        chk_all("idle_ign", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        step();
        chk_all("idle2", 32'h0040_0020, 32'd0, 32'd0, 1'b0);

        load_pc = 1'b1;
        step();
        chk_all("load", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        load_pc = 1'b0;
        step();
        chk_all("fA", 32'h0040_0024, 32'h1111_0001, 32'h0040_0024, 1'b1);
        step();
        chk_all("fB", 32'h0040_0028, 32'h2222_0002, 32'h0040_0028, 1'b1);

        stall = 1'b1;
        step();
        chk_all("stl1", 32'h0040_0028, 32'h2222_0002, 32'h0040_0028, 1'b1);
        step();
        chk_all("stl2", 32'h0040_0028, 32'h2222_0002, 32'h0040_0028, 1'b1);
        stall = 1'b0;
        step();
        chk_all("fC", 32'h0040_002C, 32'h3333_0003, 32'h0040_002C, 1'b1);

        branch_taken = 1'b1;
        stall = 1'b1;
        branch_target = 32'h0040_0103;
        step();
        chk_all("br", 32'h0040_0100, 32'd0, 32'd0, 1'b0);
        branch_taken = 1'b0;
        stall = 1'b0;
        step();
        chk_all("brT", 32'h0040_0104, 32'h5555_0005, 32'h0040_0104, 1'b1);

        branch_taken = 1'b1;
        branch_target = 32'h0040_002C;
        step();
        chk_all("br2", 32'h0040_002C, 32'd0, 32'd0, 1'b0);
        branch_taken = 1'b0;
        step();
        chk_all("fJ", 32'h0040_0030, 32'h0810_0040, 32'h0040_0030, 1'b1);

        jump = 1'b1;
        jump_index = 26'h010_0040;
        step();
        chk_all("jmp", 32'h0040_0100, 32'd0, 32'd0, 1'b0);

        branch_taken = 1'b1;
        branch_target = 32'h0040_0200;
        step();
        chk_all("brjmp", 32'h0040_0200, 32'd0, 32'd0, 1'b0);
        jump = 1'b0;

        branch_target = 32'hFFFF_FFFF;
        step();
        chk_all("toTop", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
        branch_taken = 1'b0;
        step();
        chk_all("wrap", 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);

        step();
        check("seq4", pc_out, 32'h0000_0004);

        load_pc = 1'b1;
        step();
        chk_all("reload", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        load_pc = 1'b0;
        step();
        chk_all("refA", 32'h0040_0024, 32'h1111_0001, 32'h0040_0024, 1'b1);

        reset = 1'b0;
        step();
        chk_all("mrst", 32'h0040_0020, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        step();
        chk_all("postrst", 32'h0040_0020, 32'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
